// File: rtl/huff_stream_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | huff_stream_decoder: serial prefix-code decoder with loadable code table |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module huff_stream_decoder #(
  parameter int SYMS   = 6,
  parameter int MAXLEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [2:0]        tbl_sel,
  input  logic [MAXLEN-1:0] tbl_code,
  input  logic [MAXLEN-1:0] tbl_mask,
  input  logic              start,
  input  logic              stop,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [7:0]        sym,
  input  logic              out_ready,
  output logic              err,
  output logic [15:0]       sym_cnt
);

  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  state_t            state;
  logic [MAXLEN-1:0] code_tab [1:SYMS];
  logic [MAXLEN-1:0] mask_tab [1:SYMS];
  logic [MAXLEN-1:0] shreg;
  logic [LW-1:0]     len;

  logic [MAXLEN-1:0] nsh;
  logic [LW-1:0]     nlen;
  logic              hit;
  logic [7:0]        hit_sym;
  logic              accept;
  logic              handoff;

  function automatic logic [LW-1:0] popcnt(input logic [MAXLEN-1:0] m);
    logic [LW-1:0] c;
    c = '0;
    for (int k = 0; k < MAXLEN; k++) begin
      c = c + LW'(m[k]);
    end
    return c;
  endfunction

  assign nsh       = {shreg[MAXLEN-2:0], bit_in};
  assign nlen      = len + LW'(1);
  assign bit_ready = (state == S_DECODE) && !(sym_valid && !out_ready);
  assign accept    = bit_valid && bit_ready && !stop;
  assign handoff   = sym_valid && out_ready;

  // Scan from the top entry down so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_sym = '0;
    for (int i = SYMS; i >= 1; i--) begin
      if ((mask_tab[i] != '0) && (nlen == popcnt(mask_tab[i])) &&
          ((nsh & mask_tab[i]) == (code_tab[i] & mask_tab[i]))) begin
        hit     = 1'b1;
        hit_sym = 8'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      sym       <= '0;
      err       <= 1'b0;
      sym_cnt   <= '0;
      for (int i = 1; i <= SYMS; i++) begin
        code_tab[i] <= '0;
        mask_tab[i] <= '0;
      end
    end else begin
      if (handoff) begin
        sym_cnt <= sym_cnt + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (tbl_we) begin
            for (int i = 1; i <= SYMS; i++) begin
              if (int'(tbl_sel) == i) begin
                code_tab[i] <= tbl_code;
                mask_tab[i] <= tbl_mask;
              end
            end
          end
          if (start) begin
            state <= S_DECODE;
            shreg <= '0;
            len   <= '0;
            err   <= 1'b0;
          end
        end

        S_DECODE: begin
          if (stop) begin
            state     <= S_IDLE;
            sym_valid <= 1'b0;
            shreg     <= '0;
            len       <= '0;
          end else begin
            if (handoff) begin
              sym_valid <= 1'b0;
            end
            if (accept) begin
              if (hit) begin
                sym       <= hit_sym;
                sym_valid <= 1'b1;
                shreg     <= '0;
                len       <= '0;
              end else if (nlen == LW'(MAXLEN)) begin
                err   <= 1'b1;
                state <= S_ERR;
                shreg <= '0;
                len   <= '0;
              end else begin
                shreg <= nsh;
                len   <= nlen;
              end
            end
          end
        end

        S_ERR: begin
          if (start) begin
            state <= S_DECODE;
            err   <= 1'b0;
            shreg <= '0;
            len   <= '0;
          end else if (stop) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_huff_stream_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_huff_stream_decoder: directed scoreboard bench for huff_stream_decoder |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_huff_stream_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_sel = '0;
  logic [7:0]  tbl_code = '0;
  logic [7:0]  tbl_mask = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym;
  logic        out_ready = 1'b0;
  logic        err;
  logic [15:0] sym_cnt;

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  huff_stream_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .tbl_we    (tbl_we),
    .tbl_sel   (tbl_sel),
    .tbl_code  (tbl_code),
    .tbl_mask  (tbl_mask),
    .start     (start),
    .stop      (stop),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .sym_valid (sym_valid),
    .sym       (sym),
    .out_ready (out_ready),
    .err       (err),
    .sym_cnt   (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every handoff must match the oldest expected symbol.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset && sym_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sym_unexpected: got %0d, required none", sym);
        end else begin
          e = sb_q.pop_front();
          chk("sym", 32'(sym), 32'(e));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    tbl_we    = 1'b0;
    reset     = 1'b0;
    tick();
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sym", 32'(sym), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_bit_ready", 32'(bit_ready), 0);
    chk("rst_sym_cnt", 32'(sym_cnt), 0);
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input logic [2:0] s, input logic [7:0] c, input logic [7:0] m);
    tbl_we   = 1'b1;
    tbl_sel  = s;
    tbl_code = c;
    tbl_mask = m;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic load_t1();
    load(3'd1, 8'h01, 8'h01);
    load(3'd2, 8'h01, 8'h03);
    load(3'd3, 8'h01, 8'h07);
    load(3'd4, 8'h01, 8'h0F);
    load(3'd5, 8'h01, 8'h1F);
    load(3'd6, 8'h00, 8'h1F);
  endtask

  task automatic pulse_start();
    bit_valid = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Offers one bit, waits (bounded) for acceptance, then checks whether a
  // symbol appeared right after the accepting edge. exp = 0 means none.
  task automatic send_bit(input logic b, input int exp);
    bit_valid = 1'b1;
    bit_in    = b;
    if (exp != 0) sb_q.push_back(exp);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bit_ready) break;
    end
    if (!bit_ready) begin
      checks++;
      errors++;
      $display("FAIL bit_accept_timeout: bit_ready=%0d, required 1", bit_ready);
    end
    tick();
    chk("sym_valid_after_bit", 32'(sym_valid), (exp != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    tick();
    do_reset();

    // Table load and decode: 1 | 01 | 001 | 00000 -> 1,2,3,6
    load_t1();
    out_ready = 1'b1;
    pulse_start();
    send_bit(1'b1, 1);
    send_bit(1'b0, 0); send_bit(1'b1, 2);
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 3);
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b0, 0);
    send_bit(1'b0, 0); send_bit(1'b0, 6);
    idle(2);
    chk("sym_cnt_after_4", 32'(sym_cnt), 4);

    // Backpressure: 01 -> 2 held, then 1 waits for out_ready
    send_bit(1'b0, 0);
    out_ready = 1'b0;
    send_bit(1'b1, 2);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_bit_ready", 32'(bit_ready), 0);
      chk("bp_sym_valid", 32'(sym_valid), 1);
      chk("bp_sym", 32'(sym), 2);
      chk("bp_sym_cnt", 32'(sym_cnt), 4);
    end
    tick();
    out_ready = 1'b1;
    send_bit(1'b1, 1);
    chk("bp_sym_new", 32'(sym), 1);
    idle(2);
    chk("sym_cnt_after_bp", 32'(sym_cnt), 6);

    // Error: only entry 1 loaded, eight zeros
    do_reset();
    load(3'd1, 8'h01, 8'h01);
    pulse_start();
    for (int i = 0; i < 7; i++) send_bit(1'b0, 0);
    chk("err_before_8th", 32'(err), 0);
    send_bit(1'b0, 0);
    chk("err_after_8th", 32'(err), 1);
    chk("err_bit_ready", 32'(bit_ready), 0);
    idle(2);
    chk("err_sticky", 32'(err), 1);
    chk("err_sym_valid", 32'(sym_valid), 0);
    pulse_start();
    chk("err_cleared", 32'(err), 0);
    send_bit(1'b1, 1);
    idle(2);

    // Ignored write in DECODE and overlapping entries
    do_reset();
    load(3'd2, 8'h01, 8'h03);
    load(3'd3, 8'h01, 8'h03);
    pulse_start();
    load(3'd2, 8'h00, 8'h03);
    send_bit(1'b0, 0);
    send_bit(1'b1, 2);
    idle(2);

    // Stop mid-codeword: bit offered with stop is not consumed
    do_reset();
    load_t1();
    out_ready = 1'b1;
    pulse_start();
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    bit_in = 1'b1;
    stop   = 1'b1;
    tick();
    stop      = 1'b0;
    bit_valid = 1'b0;
    chk("stop_sym_valid", 32'(sym_valid), 0);
    chk("stop_idle_bit_ready", 32'(bit_ready), 0);
    pulse_start();
    send_bit(1'b1, 1);
    send_bit(1'b0, 0);
    send_bit(1'b1, 2);
    idle(2);

    // Reset mid-stream with a pending symbol
    out_ready = 1'b0;
    pulse_start();
    send_bit(1'b1, 1);
    bit_valid = 1'b0;
    reset     = 1'b0;
    tick();
    chk("mid_rst_sym_valid", 32'(sym_valid), 0);
    chk("mid_rst_sym", 32'(sym), 0);
    chk("mid_rst_sym_cnt", 32'(sym_cnt), 0);
    chk("mid_rst_bit_ready", 32'(bit_ready), 0);
    sb_q.delete();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    chk("cleared_table_err", 32'(err), 1);

    // sym_cnt wrap
    do_reset();
    load(3'd1, 8'h01, 8'h01);
    pulse_start();
    for (int i = 0; i < 65535; i++) send_bit(1'b1, 1);
    idle(2);
    chk("sym_cnt_ffff", 32'(sym_cnt), 32'hFFFF);
    send_bit(1'b1, 1);
    idle(2);
    chk("sym_cnt_wrap", 32'(sym_cnt), 0);

    chk("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
